fsk_demod: RTL and testbench
============================

Name: fsk_demod

Overview:
- Receive-side FSK demodulator; the counterpart to the clock/tone generator that drives the transmitter.
- Measures half-periods of the incoming FSK waveform in mainclk cycles and classifies each one as a mark tone (288-cycle half-period, bit 1) or a space tone (384-cycle half-period, bit 0).
- Acquires lock, then outputs one majority-voted bit per fixed bit window.
- Feeds the downstream frame/byte assembler.

Parameters:
- MARK_HALF, 288, nominal mark half-period in mainclk cycles
- SPACE_HALF, 384, nominal space half-period in mainclk cycles
- TOL, 24, accepted deviation from either nominal value (inclusive)
- BIT_CYCLES, 6912, bit window length in mainclk cycles (24 mark / 18 space half-periods)
- ACQ_COUNT, 4, consecutive valid same-tone half-periods required for lock
- IDLE_LIMIT, 1024, edge-free cycles that cause loss of lock

Ports:
- mainclk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- fsk_in  input  1  asynchronous FSK waveform
- bit_out  output  1  last demodulated bit
- bit_valid  output  1  one-cycle strobe; bit_out is updated in the same cycle
- locked  output  1  high while in TRACK
- tone_err  output  1  one-cycle pulse when a half-period is out of tolerance in TRACK

Behaviour:
- Reset, asynchronous, active-low:
  - bit_out=0, bit_valid=0, locked=0, tone_err=0.
  - State=IDLE; all counters and synchronizer flops cleared to 0.
  - Asserting reset mid-window discards the partial window immediately.
- Input path:
  - 3-flop chain s1/s2/s3; edge = s2 XOR s3 (both polarities).
  - Fixed 3-cycle latency; this latency does not affect measured lengths.
- Half-period counter halfcnt, 10 bits:
  - Cleared to 0 in an edge cycle; otherwise increments, saturating at IDLE_LIMIT.
  - Measured length at an edge: L = halfcnt+1. An ideal input toggling every 288 cycles gives L=288.
- Classification, windows inclusive:
  - mark if MARK_HALF-TOL <= L <= MARK_HALF+TOL (264..312)
  - space if SPACE_HALF-TOL <= L <= SPACE_HALF+TOL (360..408)
  - otherwise invalid
- FSM:
  - IDLE: on first edge, clear halfcnt and acq_cnt -> ACQUIRE. No classification is made on this edge.
  - ACQUIRE: at each edge, classify L.
    - Valid and same tone as the previous one: acq_cnt+1.
    - Valid but a different tone: acq_cnt=1.
    - Invalid: acq_cnt=0.
    - When acq_cnt reaches ACQ_COUNT: -> TRACK, locked=1, bitcnt=0, mark_cnt=space_cnt=0. The locking half-period is not counted in the window.
    - halfcnt reaching IDLE_LIMIT -> IDLE.
  - TRACK:
    - bitcnt (13 bits) increments every cycle and wraps at BIT_CYCLES-1 -> 0.
    - Each edge: a mark increments mark_cnt and a space increments space_cnt (6 bits each, saturating).
    - An invalid edge pulses tone_err for one cycle and is not counted.
    - At bitcnt==BIT_CYCLES-1: bit_valid=1 for one cycle.
      - bit_out=1 if mark_cnt>space_cnt; 0 if space_cnt>mark_cnt; unchanged on a tie (including 0/0).
      - Both tallies are cleared.
      - An edge in this same cycle is counted into the new window.
    - halfcnt reaching IDLE_LIMIT -> IDLE, locked=0 in the next cycle. The partial window is dropped with no bit_valid.
- Simultaneous events:
  - A timeout takes precedence over window end in the same cycle.
  - tone_err and bit_valid may pulse together.
- Outputs are registered; bit_out holds between strobes.

Test Plan:
- Reset, then 60 mark half-periods of 288 cycles -> locked rises after the 4th classified edge; bit_valid every 6912 cycles with bit_out=1; tone_err never pulses.
- After lock, alternate space/mark for 6912 cycles each, window-aligned -> bit_out sequence 0,1,0; exactly one bit_valid per window.
- In TRACK, inject one half-period of 330 among marks -> one tone_err pulse, window still decodes 1. A half-period of 305 -> accepted, no tone_err.
- In ACQUIRE, 3 mark half-periods, then 340, then 4 marks -> no lock until the 4th mark after the 340.
- In TRACK, hold fsk_in constant -> locked=0 about 1024 cycles after the last edge; no bit_valid for the partial window; state returns to IDLE and re-locks after 4 valid half-periods.
- Assert reset at bitcnt≈3000 -> all outputs 0 immediately. After release with no input edges: locked stays 0 and bit_valid never pulses.

Source files
------------

// File: rtl/fsk_demod.sv
// rtl/fsk_demod.sv - FSK half-period demodulator with lock acquisition and majority-voted bit windows
module fsk_demod #(
    parameter int MARK_HALF  = 288,
    parameter int SPACE_HALF = 384,
    parameter int TOL        = 24,
    parameter int BIT_CYCLES = 6912,
    parameter int ACQ_COUNT  = 4,
    parameter int IDLE_LIMIT = 1024
) (
    input  logic mainclk,
    input  logic reset,
    input  logic fsk_in,
    output logic bit_out,
    output logic bit_valid,
    output logic locked,
    output logic tone_err
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    localparam logic [10:0] MARK_LO  = 11'(MARK_HALF - TOL);
    localparam logic [10:0] MARK_HI  = 11'(MARK_HALF + TOL);
    localparam logic [10:0] SPACE_LO = 11'(SPACE_HALF - TOL);
    localparam logic [10:0] SPACE_HI = 11'(SPACE_HALF + TOL);
    localparam logic [9:0]  HALF_MAX = 10'(IDLE_LIMIT - 1);
    localparam logic [12:0] WIN_LAST = 13'(BIT_CYCLES - 1);
    localparam logic [2:0]  ACQ_N    = 3'(ACQ_COUNT);

    state_t      state;
    logic        s1, s2, s3;
    logic [9:0]  halfcnt;
    logic [2:0]  acq_cnt;
    logic        prev_mark;
    logic [12:0] bitcnt;
    logic [5:0]  mark_cnt, space_cnt;

    logic        edge_det, is_mark, is_space, timeout, win_end;
    logic        mark_add, space_add;
    logic [10:0] len;
    logic [2:0]  acq_next;

    assign edge_det  = s2 ^ s3;
    assign len       = {1'b0, halfcnt} + 11'd1;
    assign is_mark   = (len >= MARK_LO) && (len <= MARK_HI);
    assign is_space  = (len >= SPACE_LO) && (len <= SPACE_HI);
    // halfcnt parks at IDLE_LIMIT-1, i.e. a measured length of IDLE_LIMIT
    assign timeout   = (halfcnt == HALF_MAX) && !edge_det;
    assign win_end   = (bitcnt == WIN_LAST);
    assign mark_add  = edge_det && is_mark;
    assign space_add = edge_det && is_space;

    always_comb begin
        acq_next = 3'd0;
        if (is_mark || is_space)
            acq_next = (acq_cnt != 3'd0 && is_mark == prev_mark) ? acq_cnt + 3'd1 : 3'd1;
    end

    always_ff @(posedge mainclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            halfcnt   <= '0;
            acq_cnt   <= '0;
            prev_mark <= 1'b0;
            bitcnt    <= '0;
            mark_cnt  <= '0;
            space_cnt <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            locked    <= 1'b0;
            tone_err  <= 1'b0;
        end else begin
            s1 <= fsk_in;
            s2 <= s1;
            s3 <= s2;
            if (edge_det)
                halfcnt <= '0;
            else if (halfcnt != HALF_MAX)
                halfcnt <= halfcnt + 10'd1;
            bit_valid <= 1'b0;
            tone_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (edge_det) begin
                        acq_cnt <= '0;
                        state   <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else if (edge_det) begin
                        acq_cnt   <= acq_next;
                        prev_mark <= is_mark;
                        if (acq_next == ACQ_N) begin
                            state     <= TRACK;
                            locked    <= 1'b1;
                            bitcnt    <= '0;
                            mark_cnt  <= '0;
                            space_cnt <= '0;
                        end
                    end
                end
                TRACK: begin
                    if (timeout) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end else begin
                        bitcnt   <= win_end ? 13'd0 : bitcnt + 13'd1;
                        tone_err <= edge_det && !is_mark && !is_space;
                        if (win_end) begin
                            bit_valid <= 1'b1;
                            if (mark_cnt > space_cnt)
                                bit_out <= 1'b1;
                            else if (space_cnt > mark_cnt)
                                bit_out <= 1'b0;
                            // an edge landing on the window boundary opens the next tally
                            mark_cnt  <= {5'd0, mark_add};
                            space_cnt <= {5'd0, space_add};
                        end else begin
                            if (mark_add && mark_cnt != 6'h3f)
                                mark_cnt <= mark_cnt + 6'd1;
                            if (space_add && space_cnt != 6'h3f)
                                space_cnt <= space_cnt + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_demod.sv
// tb/tb_fsk_demod.sv - scoreboard bench for fsk_demod driven by half-period lists
module tb_fsk_demod;

    localparam int MARK_HALF  = 288;
    localparam int SPACE_HALF = 384;
    localparam int TOL        = 24;
    localparam int BIT_CYCLES = 6912;
    localparam int ACQ_COUNT  = 4;
    localparam int IDLE_LIMIT = 1024;

    logic mainclk = 1'b0;
    logic reset   = 1'b0;
    logic fsk_in  = 1'b0;
    logic bit_out, bit_valid, locked, tone_err;

    fsk_demod dut (
        .mainclk   (mainclk),
        .reset     (reset),
        .fsk_in    (fsk_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .locked    (locked),
        .tone_err  (tone_err)
    );

    always #5 mainclk = ~mainclk;

    typedef struct {
        logic   b;
        longint when;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    int     terr_seen = 0;
    int     bv_seen = 0;

    // reference model state
    logic   m_bit = 1'b0;
    int     m_lidx, m_terr;
    logic   m_track;
    int     mt_st, mt_marks, mt_spaces;
    longint mt_wend;

    always @(posedge mainclk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge mainclk) begin
        if (tone_err) terr_seen++;
        if (bit_valid) begin
            exp_t e;
            bv_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit_valid: got strobe at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("bit_out", bit_out, e.b);
                chk("bit_valid_cycle", cyc, e.when);
            end
        end
    end

    function automatic int tone(input int l);
        if (l >= MARK_HALF - TOL && l <= MARK_HALF + TOL) return 1;
        if (l >= SPACE_HALF - TOL && l <= SPACE_HALF + TOL) return 2;
        return 0;
    endfunction

    // Emit every window whose last cycle falls strictly before lim (model time).
    task automatic close_until(input longint base, input longint lim);
        while (mt_st == 2 && mt_wend < lim) begin
            exp_t e;
            if (mt_marks > mt_spaces) m_bit = 1'b1;
            else if (mt_spaces > mt_marks) m_bit = 1'b0;
            e.b    = m_bit;
            e.when = base + mt_wend + 3;
            sb.push_back(e);
            mt_marks  = 0;
            mt_spaces = 0;
            mt_wend  += BIT_CYCLES;
        end
    endtask

    // Toggle i happens at model time t_i = sum of earlier half-periods; time 0 = first toggle.
    task automatic model(input int hp[$], input longint base);
        longint t = 0;
        int acq = 0;
        int prev = 0;
        int c;
        mt_st = 0;
        m_lidx = -1;
        m_terr = 0;
        for (int i = 0; i <= hp.size(); i++) begin
            if (i > 0) begin
                if (mt_st != 0 && hp[i-1] > IDLE_LIMIT) begin
                    close_until(base, t + IDLE_LIMIT);
                    mt_st = 0;
                end
                t += hp[i-1];
            end
            c = (i > 0) ? tone(hp[i-1]) : 0;
            if (mt_st == 0) begin
                mt_st = 1;
                acq = 0;
            end else if (mt_st == 1) begin
                if (c == 0) acq = 0;
                else if (acq > 0 && c == prev) acq++;
                else acq = 1;
                prev = c;
                if (acq == ACQ_COUNT) begin
                    mt_st = 2;
                    m_lidx = i;
                    mt_wend = t + BIT_CYCLES;
                    mt_marks = 0;
                    mt_spaces = 0;
                end
            end else begin
                close_until(base, t + 1);
                if (c == 1) mt_marks = (mt_marks < 63) ? mt_marks + 1 : 63;
                else if (c == 2) mt_spaces = (mt_spaces < 63) ? mt_spaces + 1 : 63;
                else m_terr++;
            end
        end
        m_track = (mt_st == 2);
        close_until(base, t + IDLE_LIMIT);
    endtask

    task automatic run(input int hp[$], input int hold);
        int n = hp.size();
        @(negedge mainclk);
        terr_seen = 0;
        model(hp, cyc);
        for (int i = 0; i <= n; i++) begin
            int w;
            fsk_in = ~fsk_in;
            w = (i < n) ? hp[i] : hold;
            if (i == m_lidx) chk("locked_before_lock_edge", locked, 0);
            for (int k = 1; k <= w; k++) begin
                @(negedge mainclk);
                if (i == m_lidx && k == 5) chk("locked_after_lock_edge", locked, 1);
                if (i == n && k == 1010) chk("locked_before_timeout", locked, m_track);
                if (i == n && k == 1040) chk("locked_after_timeout", locked, 0);
            end
        end
        chk("pending_bits", sb.size(), 0);
        chk("tone_err_count", terr_seen, m_terr);
    endtask

    function automatic int rand_hp();
        int bnd[8];
        int r;
        bnd = '{263, 264, 312, 313, 359, 360, 408, 409};
        r = $urandom_range(0, 9);
        if (r < 4) return $urandom_range(MARK_HALF - TOL, MARK_HALF + TOL);
        if (r < 7) return $urandom_range(SPACE_HALF - TOL, SPACE_HALF + TOL);
        if (r == 7) return bnd[$urandom_range(0, 7)];
        return $urandom_range(200, 500);
    endfunction

    initial begin
        int q[$];
        int bv_before;
        reset = 1'b0;
        fsk_in = 1'b0;
        repeat (3) @(negedge mainclk);
        chk("reset_bit_out", bit_out, 0);
        chk("reset_bit_valid", bit_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_tone_err", tone_err, 0);
        reset = 1'b1;
        repeat (5) @(negedge mainclk);

        q = {};
        repeat (60) q.push_back(MARK_HALF);
        run(q, 1100);

        q = {};
        repeat (4) q.push_back(MARK_HALF);
        repeat (18) q.push_back(SPACE_HALF);
        repeat (24) q.push_back(MARK_HALF);
        repeat (18) q.push_back(SPACE_HALF);
        run(q, 1100);

        q = {};
        repeat (4) q.push_back(MARK_HALF);
        for (int i = 0; i < 24; i++) q.push_back(i == 5 ? 330 : (i == 10 ? 305 : MARK_HALF));
        run(q, 1100);

        q = {288, 288, 288, 340, 288, 288, 288, 288, 288, 288, 288};
        run(q, 1100);

        for (int r = 0; r < 2; r++) begin
            q = {};
            if (r == 0) repeat (4) q.push_back(MARK_HALF);
            for (int i = 0; i < 24; i++) q.push_back(rand_hp());
            run(q, 1100);
        end

        q = {};
        repeat (12) q.push_back(MARK_HALF);
        run(q, 600);
        chk("locked_before_reset", locked, 1);
        reset = 1'b0;
        fsk_in = 1'b0;
        #1;
        chk("midreset_bit_out", bit_out, 0);
        chk("midreset_bit_valid", bit_valid, 0);
        chk("midreset_locked", locked, 0);
        chk("midreset_tone_err", tone_err, 0);
        m_bit = 1'b0;
        mt_st = 0;
        repeat (3) @(negedge mainclk);
        reset = 1'b1;
        bv_before = bv_seen;
        repeat (2000) @(negedge mainclk);
        chk("post_reset_locked", locked, 0);
        chk("post_reset_bit_valid_count", bv_seen, bv_before);
        chk("post_reset_bit_out", bit_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
